// File: rtl/wb_pkg.sv
// Shared writeback types: result bundle, source indices, rd decode helper.
package wb_pkg;
  localparam int WB_NSRC       = 3;
  localparam int WB_XLEN       = 32;
  localparam int WB_SRC_ALU    = 0;
  localparam int WB_SRC_LOAD   = 1;
  localparam int WB_SRC_MULDIV = 2;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'b1 << rd;
  endfunction
endpackage

// File: rtl/writeback_arbiter_rr.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          any,
  output logic [IW-1:0] idx
);
  int j;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: one slot per source, round-robin grant.
// Optional WB_PENDING_EN builds the pending-destination mask.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int NSRC = WB_NSRC,
  parameter int XLEN = WB_XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*5-1:0]    src_rd,
  input  logic [NSRC*XLEN-1:0] src_data,
  output logic                 w_enable,
  output logic [4:0]           w_addr,
  output logic [XLEN-1:0]      w_data,
  output logic [31:0]          pending
);
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] full_q, full_d;
  logic [4:0]      rd_q   [NSRC];
  logic [4:0]      rd_d   [NSRC];
  logic [XLEN-1:0] data_q [NSRC];
  logic [XLEN-1:0] data_d [NSRC];
  logic [IW-1:0]   last_q, last_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [NSRC-1:0] grant;
  logic            any;
  logic [IW-1:0]   idx;
  logic [NSRC-1:0] take;

  rr_arbiter #(.N(NSRC), .IW(IW)) u_rr (
    .req   (full_q),
    .last  (last_q),
    .grant (grant),
    .any   (any),
    .idx   (idx)
  );

  // a granted slot frees up this cycle, so its source may refill it
  assign src_ready = rst ? '0 : (~full_q | grant);
  assign take      = src_valid & src_ready;

  always_comb begin
    full_d  = full_q;
    rd_d    = rd_q;
    data_d  = data_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    for (int i = 0; i < NSRC; i++) begin
      if (take[i]) begin
        full_d[i] = 1'b1;
        rd_d[i]   = src_rd[i*5 +: 5];
        data_d[i] = src_data[i*XLEN +: XLEN];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
    if (any) begin
      last_d  = idx;
      wen_d   = (rd_q[idx] != 5'd0);
      waddr_d = rd_q[idx];
      wdata_d = data_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= '0;
      last_q  <= IW'(NSRC - 1);
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q  <= full_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign w_enable = wen_q;
  assign w_addr   = waddr_q;
  assign w_data   = wdata_q;

`ifdef WB_PENDING_EN
  logic [31:0] pend;

  always_comb begin
    pend = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (full_q[i]) pend = pend | rd_onehot(rd_q[i]);
    end
    if (wen_q) pend = pend | rd_onehot(waddr_q);
    pend[0] = 1'b0;
  end

  assign pending = pend;
`else
  assign pending = '0;
`endif
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side counterpart of the register file. Collects completed results from NSRC execution units over valid/ready handshakes, holds one result per source, picks one per cycle by round-robin, and drives the register file's single write port (`w_enable`/`w_addr`/`w_data`) from registered outputs. Also exports a pending-destination mask so decode can stall on registers with writes in flight.

## Interface

Parameters:

- `NSRC`, default 3: number of result sources; index 0 = ALU, 1 = load unit, 2 = mul/div.
- `XLEN`, default 32: data width.

Ports:

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `src_valid`  in  NSRC  source i presents a result.
- `src_ready`  out  NSRC  block accepts source i this cycle.
- `src_rd`  in  NSRC×5  destination register per source.
- `src_data`  in  NSRC×XLEN  result data per source.
- `w_enable`  out  1  register-file write strobe.
- `w_addr`  out  5  register-file write address.
- `w_data`  out  XLEN  register-file write data.
- `pending`  out  32  bit r set while a write to xr is held or presented on `w_*`; bit 0 is always 0.

## Operation

- One holding slot per source: `full[i]`, `rd[i]`, `data[i]`.
- `src_ready[i] = !full[i] || grant[i]`. This is combinational, so a source can hand over back-to-back results at one per cycle while it wins arbitration.
- Handshake: the slot is written on `src_valid[i] && src_ready[i]`. Deasserting `src_valid` without a handshake is legal and has no effect.
- Arbitration is round-robin over full slots.
  - Pointer `last` holds the most recently granted index.
  - Search order is last+1, last+2, … modulo NSRC.
  - `last` updates only when a grant occurs.
- Granted slot: cleared at the next edge, unless the same source refills it in that cycle (grant and capture on the same edge leave `full` = 1 with the new contents).
- Output register, updated every edge:
  - `w_enable <= any_grant && granted rd != 0`.
  - `w_addr`/`w_data` <= granted slot contents when any grant occurs; otherwise hold their previous values.
- rd = 0 results: accepted and arbitrated normally, but never produce `w_enable`. They still consume their grant cycle.
- Same rd from two sources: both writes occur, in grant order. Ordering hazards are the issue logic's responsibility.
- `pending`: OR over full slots of onehot(rd), plus onehot(`w_addr`) when `w_enable` is high. Bit 0 is forced to 0.

## Timing

- Latency: handshake at edge N → slot full after N → earliest `w_enable` high in the cycle after edge N+1. Minimum is 2 cycles.
- Throughput: one register write per cycle when any slot is full.
- Starvation bound: a full slot is granted within NSRC cycles.
- Reset values: all `full` = 0; `last` = NSRC-1 (so source 0 wins first); `w_enable` = 0, `w_addr` = 0, `w_data` = 0; `pending` = 0; `src_ready` = all ones once reset is released.
- Reset asserted mid-operation: held results are discarded, and no write strobe is emitted in the reset cycle or the cycle after.
- While `rst` is high, `src_ready` is 0.

## Configuration

- `WB_PENDING_EN`
  - Defined: the `pending` mask logic is built as described.
  - Undefined: `pending` is tied to 32'b0, with no logic, and decode relies on its own scoreboard.
- Arbitration, latency and write behaviour are identical in both builds.

## Structure

- Shared package `wb_pkg`:
  - `typedef wb_req_t {rd[4:0], data[XLEN-1:0]}`.
  - Source index constants `WB_SRC_ALU` = 0, `WB_SRC_LOAD` = 1, `WB_SRC_MULDIV` = 2.
  - `WB_NSRC` = 3.
- One sub-module, `rr_arbiter` (parameter N): inputs `req[N]`, `last`; outputs onehot `grant[N]`, `any`, encoded `idx`. It is purely combinational; the `last` register stays in the parent.

## Test plan

- Single ALU result, rd=5, data=0xDEADBEEF, handshaked at cycle 1 → `w_enable`=1, `w_addr`=5, `w_data`=0xDEADBEEF in cycle 3 only; `pending[5]` high in cycles 2–3.
- All three sources valid at the same cycle with rd=1/2/3 → writes to x1, x2, x3 on three consecutive cycles; with `last` at its reset value the order is 0, 1, 2.
- ALU streams rd=7 every cycle while the load unit holds rd=9 → writes alternate between x7 and x9; `src_ready[0]` never drops for more than 1 cycle.
- Result with rd=0, data=0x1234 → accepted, `w_enable` stays 0, `pending` stays 0.
- Fill all slots, then assert `rst` for 1 cycle → no `w_enable` afterwards; `pending`=0; the next handshake (rd=4, data=0x55) is written exactly 2 cycles later.
- Build without `WB_PENDING_EN`, repeat the first scenario → identical `w_*` trace; `pending` is constant 0.
